// File: rtl/dmgplus_pkg.sv
// Shared types and LCD geometry for the DMG+ video path.
package dmgplus_pkg;

  localparam int unsigned LCD_W      = 160;
  localparam int unsigned LCD_H      = 144;
  localparam int unsigned ADDR_SPLIT = 8;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned PIX_W      = 2;
  localparam int unsigned TMO_W      = 19;

  typedef enum logic [1:0] {
    MODE_LIVE  = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    LIVE = 2'd0,
    PEND = 2'd1,
    FILL = 2'd2,
    HOLD = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } vram_wr_t;

endpackage

// File: rtl/vram_pattern_gen.sv
// Combinational test-pattern pixel for a given mode and VRAM address {y, x}.
module vram_pattern_gen
  import dmgplus_pkg::*;
(
  input  mode_e             mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [PIX_W-1:0]  data_c_o
);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[15:13], addr_i[10:6], addr_i[2:0]};

  // Live mode maps to black so a clear sweep reuses the same path.
  always_comb begin
    data_c_o = '0;
    unique case (mode_i)
      MODE_LIVE:  data_c_o = 2'b00;
      MODE_SOLID: data_c_o = 2'b11;
      MODE_BARS:  data_c_o = addr_i[5:4];
      MODE_CHECK: data_c_o = addr_i[12:11] ^ addr_i[4:3];
      default:    data_c_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/vram_wr_sched.sv
// VRAM write-port scheduler: live sampler pass-through vs. frame-aligned pattern sweep.
// Define VRAM_WR_SCHED_CLEAR_EN to blank the frame with a 2'b00 sweep before returning to live.
module vram_wr_sched
  import dmgplus_pkg::*;
#(
  parameter int unsigned X_MAX     = LCD_W - 1,
  parameter int unsigned Y_MAX     = LCD_H - 1,
  parameter int unsigned FRAME_TMO = 400000
) (
  input  logic              clk_12m,
  input  logic              rstn,
  input  logic [1:0]        mode_raw,
  input  logic              frame_start,
  input  logic              smp_we,
  input  logic [ADDR_W-1:0] smp_addr,
  input  logic [PIX_W-1:0]  smp_data,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [PIX_W-1:0]  vram_data,
  output logic [1:0]        cur_mode,
  output logic              busy
);

  localparam int unsigned       CW       = ADDR_SPLIT;
  localparam logic [CW-1:0]     X_LAST   = CW'(X_MAX);
  localparam logic [CW-1:0]     Y_LAST   = CW'(Y_MAX);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(FRAME_TMO - 1);
`ifdef VRAM_WR_SCHED_CLEAR_EN
  localparam bit CLEAR_ON_LIVE = 1'b1;
`else
  localparam bit CLEAR_ON_LIVE = 1'b0;
`endif

  logic [1:0]       mode_m_q;
  mode_e            mode_s_q;
  state_e           state_q, state_d;
  mode_e            cur_mode_q, cur_mode_d;
  vram_wr_t         wr_q, wr_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    x_q, x_d, y_q, y_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [PIX_W-1:0] pat_data;

  vram_pattern_gen u_pat (
    .mode_i   (cur_mode_q),
    .addr_i   ({y_q, x_q}),
    .data_c_o (pat_data)
  );

  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    x_d        = x_q;
    y_d        = y_q;
    tmo_d      = tmo_q;
    wr_d       = wr_q;
    wr_d.we    = 1'b0;
    unique case (state_q)
      LIVE: begin
        wr_d.we   = smp_we;
        wr_d.addr = smp_addr;
        wr_d.data = smp_data;
        if (mode_s_q != cur_mode_q) begin
          state_d = PEND;
          tmo_d   = '0;
        end
      end
      PEND: begin
        wr_d.we   = smp_we;
        wr_d.addr = smp_addr;
        wr_d.data = smp_data;
        if (mode_s_q == cur_mode_q) begin
          state_d = LIVE;
        end else if (frame_start || tmo_q == TMO_LAST) begin
          cur_mode_d = mode_s_q;
          x_d        = '0;
          y_d        = '0;
          state_d    = (mode_s_q == MODE_LIVE && !CLEAR_ON_LIVE) ? LIVE : FILL;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      FILL: begin
        // A mode change discards the current write slot and restarts or aborts.
        if (mode_s_q != cur_mode_q) begin
          x_d = '0;
          y_d = '0;
          if (mode_s_q != MODE_LIVE) begin
            cur_mode_d = mode_s_q;
          end else begin
            state_d = PEND;
            tmo_d   = '0;
          end
        end else begin
          wr_d.we   = 1'b1;
          wr_d.addr = {y_q, x_q};
          wr_d.data = pat_data;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) state_d = (cur_mode_q == MODE_LIVE) ? LIVE : HOLD;
            else               y_d = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (mode_s_q != cur_mode_q) begin
          if (mode_s_q != MODE_LIVE) begin
            cur_mode_d = mode_s_q;
            x_d        = '0;
            y_d        = '0;
            state_d    = FILL;
          end else begin
            state_d = PEND;
            tmo_d   = '0;
          end
        end
      end
      default: state_d = LIVE;
    endcase
    busy_d = (state_d == PEND) || (state_d == FILL);
  end

  always_ff @(posedge clk_12m or negedge rstn) begin
    if (!rstn) begin
      mode_m_q   <= '0;
      mode_s_q   <= MODE_LIVE;
      state_q    <= LIVE;
      cur_mode_q <= MODE_LIVE;
      wr_q       <= '0;
      busy_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      tmo_q      <= '0;
    end else begin
      mode_m_q   <= mode_raw;
      mode_s_q   <= mode_e'(mode_m_q);
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      tmo_q      <= tmo_d;
    end
  end

  assign vram_we   = wr_q.we;
  assign vram_addr = wr_q.addr;
  assign vram_data = wr_q.data;
  assign cur_mode  = cur_mode_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vram_wr_sched.sv
// Scoreboard bench for vram_wr_sched: expected writes queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_vram_wr_sched;

  localparam int unsigned TB_TMO = 200;
  localparam int unsigned SWEEP  = 23040;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  data;
  } exp_t;

  logic        clk_12m = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  mode_raw = 2'd0;
  logic        frame_start = 1'b0;
  logic        smp_we = 1'b0;
  logic [15:0] smp_addr = 16'h0;
  logic [1:0]  smp_data = 2'b00;
  logic        vram_we;
  logic [15:0] vram_addr;
  logic [1:0]  vram_data;
  logic [1:0]  cur_mode;
  logic        busy;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  logic [15:0] last_addr = 16'h0;

  vram_wr_sched #(.FRAME_TMO(TB_TMO)) dut (
    .clk_12m     (clk_12m),
    .rstn        (rstn),
    .mode_raw    (mode_raw),
    .frame_start (frame_start),
    .smp_we      (smp_we),
    .smp_addr    (smp_addr),
    .smp_data    (smp_data),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data),
    .cur_mode    (cur_mode),
    .busy        (busy)
  );

  always #5 clk_12m = ~clk_12m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model(input int m, input logic [15:0] a);
    case (m)
      1:       return 2'b11;
      2:       return 2'(a >> 4);
      3:       return 2'((a >> 11) ^ (a >> 3));
      default: return 2'b00;
    endcase
  endfunction

  task automatic push_sweep(input int m, input int n, input int lit_idx, input logic [1:0] lit_data);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = {8'(i / 160), 8'(i % 160)};
      e.data = (i == lit_idx) ? lit_data : model(m, e.addr);
      sb_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk_12m);
    #1;
  endtask

  task automatic wait_q(input int target, input int max, input string name);
    int n = 0;
    while (sb_q.size() > target && n < max) begin
      tick();
      n++;
    end
    chk(name, 32'(sb_q.size()), 32'(target));
  endtask

  // Monitor: every DUT write must match the head of the expected queue.
  always @(negedge clk_12m) begin
    if (vram_we) begin
      wr_cnt++;
      last_addr = vram_addr;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %b, required no write", vram_addr, vram_data);
      end else begin
        mon_e = sb_q.pop_front();
        if (vram_addr !== mon_e.addr || vram_data !== mon_e.data) begin
          errors++;
          $display("FAIL write_seq: got addr %h data %b required addr %h data %b",
                   vram_addr, vram_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    int n;
    int cnt0;
    #2;
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_data", vram_data, 0);
    chk("rst_mode", cur_mode, 0);
    chk("rst_busy", busy, 0);
    #10 rstn = 1'b1;
    tick(); tick();

    // Live pass-through
    sb_q.push_back('{16'h0A05, 2'b10});
    smp_we = 1'b1; smp_addr = 16'h0A05; smp_data = 2'b10;
    tick();
    sb_q.push_back('{16'h0B07, 2'b01});
    smp_addr = 16'h0B07; smp_data = 2'b01;
    tick();
    smp_we = 1'b0; smp_addr = 16'h0C00;
    tick(); tick();
    chk("live_idle_addr", vram_addr, 32'h0C00);
    chk("live_idle_we", vram_we, 0);
    chk("live_busy", busy, 0);
    chk("live_drain", 32'(sb_q.size()), 0);

    // Blip cancel
    mode_raw = 2'd3;
    repeat (4) tick();
    chk("blip_pend_busy", busy, 1);
    chk("blip_pend_mode", cur_mode, 0);
    mode_raw = 2'd0;
    repeat (4) tick();
    chk("blip_busy", busy, 0);
    chk("blip_mode", cur_mode, 0);

    // Frame-aligned commit to bars, sampler write coincident with frame_start
    mode_raw = 2'd2;
    repeat (50) tick();
    chk("pend_busy", busy, 1);
    chk("pend_mode", cur_mode, 0);
    sb_q.push_back('{16'h1234, 2'b01});
    push_sweep(2, SWEEP, 48, 2'b11);
    frame_start = 1'b1; smp_we = 1'b1; smp_addr = 16'h1234; smp_data = 2'b01;
    tick();
    frame_start = 1'b0; smp_we = 1'b0;
    chk("commit_mode", cur_mode, 2);
    cnt0 = wr_cnt;
    n = 0;
    while (busy && n < SWEEP + 100) begin tick(); n++; end
    chk("sweep_busy_fall", busy, 0);
    chk("sweep_count", 32'(wr_cnt - cnt0), SWEEP);
    chk("sweep_last_addr", last_addr, 32'h8F9F);
    chk("sweep_drain", 32'(sb_q.size()), 0);
    repeat (20) tick();
    chk("hold_busy", busy, 0);
    chk("hold_mode", cur_mode, 2);

    // Back to live through the frame timeout
`ifdef VRAM_WR_SCHED_CLEAR_EN
    push_sweep(0, SWEEP, -1, 2'b00);
`endif
    mode_raw = 2'd0;
    cnt0 = wr_cnt;
    n = 0;
    while ((cur_mode != 2'd0 || busy) && n < TB_TMO + SWEEP + 100) begin tick(); n++; end
    chk("relive_mode", cur_mode, 0);
    chk("relive_busy", busy, 0);
`ifdef VRAM_WR_SCHED_CLEAR_EN
    chk("clear_count", 32'(wr_cnt - cnt0), SWEEP);
`endif
    chk("relive_drain", 32'(sb_q.size()), 0);
    sb_q.push_back('{16'h0F10, 2'b11});
    smp_we = 1'b1; smp_addr = 16'h0F10; smp_data = 2'b11;
    tick();
    smp_we = 1'b0;
    tick();
    chk("relive_passthru", 32'(sb_q.size()), 0);

    // Timeout commit to solid, then switch to checker mid-sweep
    push_sweep(1, 102, -1, 2'b00);
    mode_raw = 2'd1;
    n = 0;
    while (cur_mode != 2'd1 && n < 1000) begin tick(); n++; end
    chk("tmo_lo", 32'(n >= TB_TMO - 3), 1);
    chk("tmo_hi", 32'(n <= TB_TMO + 3), 1);
    wait_q(2, 300, "solid_progress");
    mode_raw = 2'd3;
    push_sweep(3, 1289, 1288, 2'b00);
    wait_q(0, 2000, "check_drain");

    // Async reset mid-sweep
    rstn = 1'b0;
    #1;
    chk("arst_we", vram_we, 0);
    chk("arst_mode", cur_mode, 0);
    chk("arst_busy", busy, 0);
    mode_raw = 2'd0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (10) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mode", cur_mode, 0);
    chk("post_rst_drain", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
